stopwatch_timer_ctrl: RTL and testbench
=======================================

# stopwatch_timer_ctrl

Parametrised successor to the stopwatch control path. It holds the time counter itself, counting up with modulo wrap or down from a loaded preset with auto-expiry. An optional lap-capture FIFO can be compiled in. It sits between the debounced button pulses / timebase tick and the display and readout logic.

## Interface
Parameters:
- `WIDTH`, 16: counter width in bits.
- `MAX_COUNT`, 5999: highest up-count value; must be < 2**WIDTH.
- `LAP_DEPTH`, 4: lap FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle timebase enable.
- `start_btn`, `stop_btn`, `clear_btn`, `mode_btn`, `lap_btn`  in  1 each  one-cycle, clk-synchronous command pulses.
- `load`  in  1  one-cycle pulse: load `preset`.
- `preset`  in  WIDTH  countdown start value.
- `lap_rd`  in  1  pop lap FIFO head.
- `count`  out  WIDTH  current time value.
- `running`  out  1  high in RUN.
- `dir`  out  1  1 = up, 0 = down.
- `expired`  out  1  one-cycle pulse on countdown reaching 0.
- `wrapped`  out  1  one-cycle pulse on up-count wrap MAX_COUNT→0.
- `lap_data`  out  WIDTH  FIFO head (valid when lap_valid).
- `lap_valid`  out  1  FIFO not empty.
- `lap_full`  out  1  FIFO full.
- `lap_ovf`  out  1  sticky: lap pushed while full.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset: IDLE; count=0, dir=1, running=0, expired=0, wrapped=0, FIFO empty, lap_ovf=0.
- mode_btn: toggles dir in any state except RUN; ignored in RUN.
- load, in any state except RUN: count ← min(preset, MAX_COUNT); state → IDLE. Ignored in RUN.
- clear, in any state except RUN: count ← 0; state → IDLE; FIFO flushed; lap_ovf ← 0. Ignored in RUN.
- start in IDLE or HOLD: → RUN, except when dir=0 and count=0 (ignored). Ignored in DONE.
- stop in RUN: → HOLD.
- Priority in one cycle:
  - stop > start; both asserted in RUN → HOLD.
  - stop > tick; the count does not advance.
  - clear > load > mode (non-RUN states).
- tick in RUN, up: count==MAX_COUNT ? 0 with wrapped pulse : count+1.
- tick in RUN, down: count−1. When the result is 0: → DONE, expired pulse, running drops.
- Counting does not saturate in either direction except through DONE.
- lap_btn in RUN pushes the pre-tick count value. lap_btn in other states is ignored.
- Push while full: entry dropped, lap_ovf ← 1.
- lap_rd with lap_valid pops the head. lap_rd while empty is ignored.
- Push and pop in the same cycle are both performed; when full, the push is accepted because a slot frees.

## Timing
- All outputs registered; lap_data is the registered FIFO head.
- Command or tick at edge N: count, state, running and dir are valid after edge N.
- expired and wrapped are high for exactly the cycle after the causing tick.
- Lap push is visible on lap_valid one cycle after lap_btn. lap_data updates one cycle after lap_rd.
- Asserting rst_n low mid-run clears everything immediately, with no clock required. The first command is accepted on the first edge after release.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined: lap FIFO, lap_btn, lap_rd and lap outputs behave as above.
- Undefined: no FIFO storage is built; lap_btn and lap_rd are ignored; lap_data=0, lap_valid=0, lap_full=0, lap_ovf=0 constantly. Ports remain present.

## Test plan
- Up wrap: MAX_COUNT=9, start, 12 ticks → count sequence ends at 2; wrapped pulses once at tick 10.
- Countdown: dir→0, preset=3, load, start, 3 ticks → count 2,1,0; expired one cycle; state DONE; a later start is ignored until load or clear.
- Zero-start guard: dir=0, count=0, start → running stays 0. Then stop and tick in the same cycle during RUN → HOLD with count unchanged.
- Lap FIFO (LAP_DEPTH=4): 5 laps at counts 1–5 → lap_full, lap_ovf=1; pops return 1,2,3,4; clear in HOLD resets lap_ovf.
- Simultaneous push and pop when full → occupancy unchanged; the new count is at the tail.
- Reset mid-run at count 7 → all outputs at reset values without a clock edge. With `STOPWATCH_LAP_EN` undefined, all lap outputs stay 0 throughout.

Source files
------------

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch/timer control path: up/down time counter, IDLE/RUN/HOLD/DONE FSM,
// optional lap-capture FIFO compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_timer_ctrl #(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 5999,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             clear_btn,
  input  logic             mode_btn,
  input  logic             lap_btn,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             lap_rd,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             dir,
  output logic             expired,
  output logic             wrapped,
  output logic [WIDTH-1:0] lap_data,
  output logic             lap_valid,
  output logic             lap_full,
  output logic             lap_ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  state_t           state_r, state_n;
  logic [WIDTH-1:0] count_r, count_n;
  logic             dir_r, dir_n;
  logic             running_r, expired_r, wrapped_r, expired_n, wrapped_n;
  logic             push_s, flush_s;

  // Next-state, counter and command decode
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    dir_n     = dir_r;
    expired_n = 1'b0;
    wrapped_n = 1'b0;
    push_s    = 1'b0;
    flush_s   = 1'b0;
    case (state_r)
      RUN: begin
        push_s = lap_btn;
        if (stop_btn) begin
          state_n = HOLD;
        end else if (tick) begin
          if (dir_r) begin
            if (count_r == MAX_C) begin
              count_n   = '0;
              wrapped_n = 1'b1;
            end else begin
              count_n = count_r + WIDTH'(1);
            end
          end else begin
            count_n = count_r - WIDTH'(1);
            if (count_r == WIDTH'(1)) begin
              state_n   = DONE;
              expired_n = 1'b1;
            end else begin
              state_n = RUN;
            end
          end
        end else begin
          state_n = RUN;
        end
      end
      IDLE, HOLD, DONE: begin
        // clear > load > mode > start; a countdown from zero never starts
        if (clear_btn) begin
          count_n = '0;
          state_n = IDLE;
          flush_s = 1'b1;
        end else if (load) begin
          count_n = (preset > MAX_C) ? MAX_C : preset;
          state_n = IDLE;
        end else if (mode_btn) begin
          dir_n = ~dir_r;
        end else if (start_btn && (state_r != DONE) && (dir_r || (count_r != '0))) begin
          state_n = RUN;
        end else begin
          state_n = state_r;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= '0;
      dir_r     <= 1'b1;
      running_r <= 1'b0;
      expired_r <= 1'b0;
      wrapped_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      dir_r     <= dir_n;
      running_r <= (state_n == RUN);
      expired_r <= expired_n;
      wrapped_r <= wrapped_n;
    end
  end

  assign count   = count_r;
  assign running = running_r;
  assign dir     = dir_r;
  assign expired = expired_r;
  assign wrapped = wrapped_r;

`ifdef STOPWATCH_LAP_EN
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(LAP_DEPTH);

  logic [WIDTH-1:0] mem_r [LAP_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      occ_r, occ_n;
  logic [WIDTH-1:0] lap_data_r, head_n;
  logic             lap_valid_r, lap_full_r, lap_ovf_r;
  logic             full_s, pop_s, push_ok_s;

  // FIFO occupancy and registered-head lookahead
  always_comb begin
    full_s    = (occ_r == DEPTH_C);
    pop_s     = lap_rd && (occ_r != '0);
    push_ok_s = push_s && (!full_s || pop_s);
    occ_n     = occ_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_s);
    if (pop_s && (occ_r > (AW+1)'(1))) begin
      head_n = mem_r[rd_ptr_r + AW'(1)];
    end else if (push_ok_s && ((occ_r == '0) || pop_s)) begin
      head_n = count_r;
    end else begin
      head_n = lap_data_r;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= count_r;
    end
  end

  // FIFO pointers, flags and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= '0;
      lap_data_r  <= '0;
      lap_valid_r <= 1'b0;
      lap_full_r  <= 1'b0;
      lap_ovf_r   <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= '0;
      lap_data_r  <= '0;
      lap_valid_r <= 1'b0;
      lap_full_r  <= 1'b0;
      lap_ovf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !push_ok_s) begin
        lap_ovf_r <= 1'b1;
      end
      occ_r       <= occ_n;
      lap_data_r  <= head_n;
      lap_valid_r <= (occ_n != '0);
      lap_full_r  <= (occ_n == DEPTH_C);
    end
  end

  assign lap_data  = lap_data_r;
  assign lap_valid = lap_valid_r;
  assign lap_full  = lap_full_r;
  assign lap_ovf   = lap_ovf_r;
`else
  logic unused_s;
  assign unused_s  = ^{lap_btn, lap_rd, push_s, flush_s};
  assign lap_data  = '0;
  assign lap_valid = 1'b0;
  assign lap_full  = 1'b0;
  assign lap_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed self-checking bench for stopwatch_timer_ctrl (MAX_COUNT=9, LAP_DEPTH=4);
// lap FIFO scenarios run when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_timer_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic        mode_btn = 1'b0, lap_btn = 1'b0, load = 1'b0, lap_rd = 1'b0;
  logic [15:0] preset = 16'd0;
  logic [15:0] count, lap_data;
  logic        running, dir, expired, wrapped, lap_valid, lap_full, lap_ovf;
  int          compared = 0;
  int          mismatched = 0;

  stopwatch_timer_ctrl #(.WIDTH(16), .MAX_COUNT(9), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .mode_btn(mode_btn), .lap_btn(lap_btn), .load(load),
    .preset(preset), .lap_rd(lap_rd), .count(count), .running(running), .dir(dir),
    .expired(expired), .wrapped(wrapped), .lap_data(lap_data), .lap_valid(lap_valid),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
    mode_btn = 1'b0; lap_btn = 1'b0; load = 1'b0; lap_rd = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({count, running, dir, expired, wrapped} !== {16'd0, 4'b0100}) begin
      mismatched++;
      $display("FAIL reset_state: count=%0d run/dir/exp/wrap=%b expected 0/0100", count, {running, dir, expired, wrapped});
    end
    compared++;
    if ({lap_data, lap_valid, lap_full, lap_ovf} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_lap: data=%0d v/f/o=%b expected 0/000", lap_data, {lap_valid, lap_full, lap_ovf});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    start_btn = 1'b1; step();
    compared++;
    if ({running, count} !== {1'b1, 16'd0}) begin
      mismatched++;
      $display("FAIL up_start: running=%b count=%0d expected 1/0", running, count);
    end
    for (int i = 1; i <= 12; i++) begin
      tick = 1'b1; step();
      compared++;
      if ({count, wrapped} !== {16'(i % 10), (i == 10)}) begin
        mismatched++;
        $display("FAIL up_tick%0d: count=%0d wrapped=%b expected %0d/%b", i, count, wrapped, i % 10, (i == 10));
      end
    end
    stop_btn = 1'b1; step();
    compared++;
    if ({running, count} !== {1'b0, 16'd2}) begin
      mismatched++;
      $display("FAIL up_stop: running=%b count=%0d expected 0/2", running, count);
    end
  endtask

  task automatic test_stop_priority();
    start_btn = 1'b1; step();
    tick = 1'b1; step();
    compared++;
    if ({running, count} !== {1'b1, 16'd3}) begin
      mismatched++;
      $display("FAIL resume_tick: running=%b count=%0d expected 1/3", running, count);
    end
    stop_btn = 1'b1; tick = 1'b1; step();
    compared++;
    if ({running, count} !== {1'b0, 16'd3}) begin
      mismatched++;
      $display("FAIL stop_tick: running=%b count=%0d expected 0/3", running, count);
    end
    start_btn = 1'b1; step();
    stop_btn = 1'b1; start_btn = 1'b1; step();
    compared++;
    if (running !== 1'b0) begin
      mismatched++;
      $display("FAIL stop_start: running=%b expected 0", running);
    end
  endtask

  task automatic test_run_ignores();
    start_btn = 1'b1; step();
    mode_btn = 1'b1; step();
    load = 1'b1; preset = 16'd5; step();
    clear_btn = 1'b1; step();
    compared++;
    if ({running, dir, count} !== {2'b11, 16'd3}) begin
      mismatched++;
      $display("FAIL run_ignore: run/dir=%b count=%0d expected 11/3", {running, dir}, count);
    end
    stop_btn = 1'b1; step();
  endtask

  task automatic test_load_priority();
    clear_btn = 1'b1; load = 1'b1; mode_btn = 1'b1; preset = 16'd6; step();
    compared++;
    if ({dir, count} !== {1'b1, 16'd0}) begin
      mismatched++;
      $display("FAIL clear_prio: dir=%b count=%0d expected 1/0", dir, count);
    end
    load = 1'b1; mode_btn = 1'b1; preset = 16'd6; step();
    compared++;
    if ({dir, count} !== {1'b1, 16'd6}) begin
      mismatched++;
      $display("FAIL load_prio: dir=%b count=%0d expected 1/6", dir, count);
    end
    load = 1'b1; preset = 16'd20; step();
    compared++;
    if (count !== 16'd9) begin
      mismatched++;
      $display("FAIL load_clamp: count=%0d expected 9", count);
    end
    clear_btn = 1'b1; step();
  endtask

  task automatic test_countdown();
    mode_btn = 1'b1; step();
    compared++;
    if (dir !== 1'b0) begin
      mismatched++;
      $display("FAIL mode_dir: dir=%b expected 0", dir);
    end
    start_btn = 1'b1; step();
    compared++;
    if (running !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_guard: running=%b expected 0", running);
    end
    load = 1'b1; preset = 16'd3; step();
    start_btn = 1'b1; step();
    for (int i = 1; i <= 3; i++) begin
      tick = 1'b1; step();
      compared++;
      if ({count, expired, running} !== {16'(3 - i), (i == 3), (i != 3)}) begin
        mismatched++;
        $display("FAIL down_tick%0d: count=%0d exp/run=%b expected %0d/%b%b", i, count, {expired, running}, 3 - i, (i == 3), (i != 3));
      end
    end
    start_btn = 1'b1; step();
    compared++;
    if ({expired, running, count} !== {2'b00, 16'd0}) begin
      mismatched++;
      $display("FAIL done_start: exp/run=%b count=%0d expected 00/0", {expired, running}, count);
    end
    load = 1'b1; preset = 16'd2; step();
    start_btn = 1'b1; step();
    compared++;
    if ({running, count} !== {1'b1, 16'd2}) begin
      mismatched++;
      $display("FAIL reload_start: running=%b count=%0d expected 1/2", running, count);
    end
    stop_btn = 1'b1; step();
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; preset = 16'd9; step();
    start_btn = 1'b1; step();
    tick = 1'b1; step();
    tick = 1'b1; step();
    compared++;
    if ({running, dir, count} !== {2'b10, 16'd7}) begin
      mismatched++;
      $display("FAIL pre_reset: run/dir=%b count=%0d expected 10/7", {running, dir}, count);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({count, running, dir, expired, wrapped, lap_valid, lap_full, lap_ovf} !== {16'd0, 7'b0100000}) begin
      mismatched++;
      $display("FAIL async_reset: count=%0d flags=%b expected 0/0100000", count, {running, dir, expired, wrapped, lap_valid, lap_full, lap_ovf});
    end
    #3 rst_n = 1'b1;
    start_btn = 1'b1; step();
    compared++;
    if (running !== 1'b1) begin
      mismatched++;
      $display("FAIL first_cmd: running=%b expected 1", running);
    end
    stop_btn = 1'b1; step();
    clear_btn = 1'b1; step();
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap_fifo();
    start_btn = 1'b1; step();
    tick = 1'b1; step();
    for (int i = 1; i <= 5; i++) begin
      tick = 1'b1; lap_btn = 1'b1; step();
      if (i == 1) begin
        compared++;
        if ({lap_valid, lap_data} !== {1'b1, 16'd1}) begin
          mismatched++;
          $display("FAIL lap_first: valid=%b data=%0d expected 1/1", lap_valid, lap_data);
        end
      end
    end
    stop_btn = 1'b1; step();
    compared++;
    if ({lap_full, lap_ovf, lap_data} !== {2'b11, 16'd1}) begin
      mismatched++;
      $display("FAIL lap_ovf: full/ovf=%b data=%0d expected 11/1", {lap_full, lap_ovf}, lap_data);
    end
    for (int i = 2; i <= 4; i++) begin
      lap_rd = 1'b1; step();
      compared++;
      if ({lap_valid, lap_data} !== {1'b1, 16'(i)}) begin
        mismatched++;
        $display("FAIL lap_pop%0d: valid=%b data=%0d expected 1/%0d", i, lap_valid, lap_data, i);
      end
    end
    lap_rd = 1'b1; step();
    compared++;
    if ({lap_valid, lap_ovf} !== 2'b01) begin
      mismatched++;
      $display("FAIL lap_empty: valid/ovf=%b expected 01", {lap_valid, lap_ovf});
    end
    clear_btn = 1'b1; step();
    compared++;
    if ({lap_valid, lap_full, lap_ovf, count} !== {3'b000, 16'd0}) begin
      mismatched++;
      $display("FAIL lap_clear: v/f/o=%b count=%0d expected 000/0", {lap_valid, lap_full, lap_ovf}, count);
    end
  endtask

  task automatic test_back_to_back();
    start_btn = 1'b1; step();
    for (int i = 1; i <= 4; i++) begin
      tick = 1'b1; step();
      lap_btn = 1'b1; step();
    end
    tick = 1'b1; step();
    lap_btn = 1'b1; lap_rd = 1'b1; step();
    compared++;
    if ({lap_full, lap_ovf, lap_data} !== {2'b10, 16'd2}) begin
      mismatched++;
      $display("FAIL pushpop_full: full/ovf=%b data=%0d expected 10/2", {lap_full, lap_ovf}, lap_data);
    end
    for (int i = 3; i <= 5; i++) begin
      lap_rd = 1'b1; step();
      compared++;
      if (lap_data !== 16'(i)) begin
        mismatched++;
        $display("FAIL pushpop_drain%0d: data=%0d expected %0d", i, lap_data, i);
      end
    end
    stop_btn = 1'b1; step();
    clear_btn = 1'b1; step();
  endtask
`else
  task automatic test_lap_disabled();
    start_btn = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; lap_btn = 1'b1; lap_rd = (i == 2); step();
      compared++;
      if ({lap_data, lap_valid, lap_full, lap_ovf} !== 19'd0) begin
        mismatched++;
        $display("FAIL lap_off%0d: data=%0d v/f/o=%b expected 0/000", i, lap_data, {lap_valid, lap_full, lap_ovf});
      end
    end
    stop_btn = 1'b1; step();
    clear_btn = 1'b1; step();
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_stop_priority();
    test_run_ignores();
    test_load_priority();
    test_countdown();
    clear_btn = 1'b1; step();
`ifdef STOPWATCH_LAP_EN
    mode_btn = 1'b1; step();
    test_lap_fifo();
    test_back_to_back();
`else
    mode_btn = 1'b1; step();
    test_lap_disabled();
`endif
    mode_btn = 1'b1; step();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
